window_gen_3x3: RTL and testbench

//  Streaming 3x3 sliding-window generator that sits directly upstream of the 9-tap multiplier bar.

---
 rtl/window_gen_3x3_pkg.sv | 21 ++
 rtl/window_gen_3x3_if.sv | 29 ++
 rtl/window_gen_3x3_line_buffer.sv | 31 +++
 rtl/window_gen_3x3.sv | 145 ++++++++++++++
 tb/tb_window_gen_3x3.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/window_gen_3x3_pkg.sv
// Shared CNN front-end definitions: pixel format, kernel geometry and the
// row-major window indexing used by the window generator and downstream taps.
package window_gen_3x3_pkg;

    localparam int DW       = 8;
    localparam int KERNEL   = 3;
    localparam int WIN_TAPS = KERNEL * KERNEL;

    // Window rows, oldest image row first (win1..win3 come from ROW_OLD).
    localparam int ROW_OLD = 0;
    localparam int ROW_MID = 1;
    localparam int ROW_NEW = 2;

    typedef logic signed [DW-1:0] pixel_t;

    // Flat row-major tap index: (0,0) -> win1 ... (2,2) -> win9.
    function automatic int win_idx(input int row, input int col);
        return row * KERNEL + col;
    endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in / 3x3 window out bundle between the feature-map source,
// the window generator and the 9-tap multiplier bar.
interface window_gen_3x3_if;
    import window_gen_3x3_pkg::*;

    pixel_t pix_i;
    logic   pix_valid_i;
    logic   sof_i;

    pixel_t win1, win2, win3;
    pixel_t win4, win5, win6;
    pixel_t win7, win8, win9;
    logic   win_valid_o;
    logic   frame_done_o;

    // Pixel source side.
    modport master (
        output pix_i, pix_valid_i, sof_i,
        input  win1, win2, win3, win4, win5, win6, win7, win8, win9,
        input  win_valid_o, frame_done_o
    );

    // Window generator side.
    modport slave (
        input  pix_i, pix_valid_i, sof_i,
        output win1, win2, win3, win4, win5, win6, win7, win8, win9,
        output win_valid_o, frame_done_o
    );
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One image row of pixel storage: circular RAM addressed by column, with an
// asynchronous read so the old contents are seen in the same cycle they are
// overwritten (read-before-write).
module window_gen_3x3_line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    // Old row contents at this column, before this cycle's write lands.
    assign rdata = mem[addr];

    // Store the incoming pixel for use one row later.
    // NOTE: the storage array has no reset; its contents are overwritten before
    // they can reach a valid window, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator. Tracks the raster position of each
// accepted pixel, keeps the two previous rows in line buffers, and presents a
// registered window one cycle after every fully interior pixel.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic             clk,
    input  logic             rst,
    window_gen_3x3_if.slave  bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef logic [CW-1:0] col_t;
    typedef logic [RW-1:0] row_t;

    localparam col_t COL_LAST = col_t'(IMG_W - 1);
    localparam row_t ROW_LAST = row_t'(IMG_H - 1);
    localparam col_t COL_MIN  = col_t'(KERNEL - 1);
    localparam row_t ROW_MIN  = row_t'(KERNEL - 1);

    logic   accept;
    col_t   col_q, cur_col;
    row_t   row_q, cur_row;
    logic   fire, last_pix;

    pixel_t lb0_rd, lb1_rd;
    pixel_t newest   [KERNEL];
    pixel_t hist_q   [KERNEL][KERNEL-1];
    pixel_t hist_nxt [KERNEL][KERNEL-1];
    pixel_t win_nxt  [WIN_TAPS];
    pixel_t win_q    [WIN_TAPS];
    logic   win_valid_q, frame_done_q;

    assign accept = bus.pix_valid_i;

    // Position of the pixel being accepted; sof_i pins it to (0,0).
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned and a latch is never inferred.
        cur_col = col_q;
        cur_row = row_q;
        if (bus.sof_i) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    assign fire     = accept && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
    assign last_pix = accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    // lb0 holds the previous row, lb1 the row before that; lb1 is fed from lb0.
    window_gen_3x3_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (bus.pix_i),
        .rdata (lb0_rd)
    );

    window_gen_3x3_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Assemble the window ending at the current column: two older columns from
    // the tap history, the newest column live from the line buffers and input.
    always_comb begin
        newest   = '{default: '0};
        win_nxt  = '{default: '0};
        hist_nxt = hist_q;
        newest[ROW_OLD] = lb1_rd;
        newest[ROW_MID] = lb0_rd;
        newest[ROW_NEW] = bus.pix_i;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_nxt[win_idx(r, c)] = hist_q[r][c];
            end
            win_nxt[win_idx(r, KERNEL - 1)] = newest[r];
        end
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                hist_nxt[r][c] = win_nxt[win_idx(r, c + 1)];
            end
        end
    end

    // Raster counters: advance per accepted pixel, wrap at row and frame end.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + row_t'(1);
            end else begin
                col_q <= cur_col + col_t'(1);
                row_q <= cur_row;
            end
        end
    end

    // Tap history shifts on every accepted pixel; window registers load only
    // for interior positions and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q       <= '{default: '0};
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= fire;
            frame_done_q <= last_pix;
            if (accept) begin
                hist_q <= hist_nxt;
            end
            if (fire) begin
                win_q <= win_nxt;
            end
        end
    end

    assign bus.win1         = win_q[0];
    assign bus.win2         = win_q[1];
    assign bus.win3         = win_q[2];
    assign bus.win4         = win_q[3];
    assign bus.win5         = win_q[4];
    assign bus.win6         = win_q[5];
    assign bus.win7         = win_q[6];
    assign bus.win8         = win_q[7];
    assign bus.win9         = win_q[8];
    assign bus.win_valid_o  = win_valid_q;
    assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 image.
module tb_window_gen_3x3;
    import window_gen_3x3_pkg::*;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_gen_3x3_if bus ();

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  img [NPIX];
    logic [73:0] obs_q [$];
    logic [73:0] exp_q [$];
    logic [71:0] last_win;
    int          gap_bad;

    // {win_valid, frame_done, win1..win9} with win1 in the top byte.
    function automatic logic [73:0] snap();
        return {bus.win_valid_o, bus.frame_done_o,
                bus.win1, bus.win2, bus.win3, bus.win4, bus.win5,
                bus.win6, bus.win7, bus.win8, bus.win9};
    endfunction

    // One clock: drive on the falling edge, return just after the rising edge.
    task automatic push(input logic [7:0] p, input logic sof, input logic valid);
        @(negedge clk);
        bus.pix_i       = p;
        bus.sof_i       = sof;
        bus.pix_valid_i = valid;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_img(input int base);
        for (int i = 0; i < NPIX; i++) img[i] = 8'(base + i);
    endtask

    // Streams img[0..n-1], recording outputs after each accepted pixel; any
    // strobe seen during an idle cycle is tallied in gap_bad.
    task automatic send_frame(input bit sof_first, input bit gaps, input int n);
        logic [73:0] s;
        obs_q.delete();
        gap_bad = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) begin
                    push(8'h00, 1'b0, 1'b0);
                    s = snap();
                    if (s[73:72] != 2'b00) gap_bad++;
                end
            end
            push(img[i], sof_first && (i == 0), 1'b1);
            obs_q.push_back(snap());
        end
        push(8'h00, 1'b0, 1'b0);
        s = snap();
        if (s[73:72] != 2'b00) gap_bad++;
    endtask

    // Reference: window read straight from the image array, held between strobes.
    task automatic model_frame(input int n);
        int r, c;
        logic v, fd;
        logic [71:0] w;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            r  = i / W;
            c  = i % W;
            v  = (r >= 2) && (c >= 2);
            fd = (i == NPIX - 1);
            if (v) begin
                w = '0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        w = (w << 8) | {64'b0, img[(r - 2 + a) * W + (c - 2 + b)]};
                last_win = w;
            end
            exp_q.push_back({v, fd, last_win});
        end
    endtask

    function automatic int count_strobes();
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][73]) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][72]) n++;
        return n;
    endfunction

    task automatic test_reset();
        logic [73:0] s;
        bus.pix_i = '0; bus.pix_valid_i = 1'b0; bus.sof_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s = snap();
        checks++;
        if (s !== 74'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", s);
        end
        @(negedge clk);
        rst = 1'b0;
        last_win = '0;
    endtask

    task automatic test_continuous();
        logic [71:0] w;
        fill_img(0);
        send_frame(1'b1, 1'b0, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL cont px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        w = obs_q[12][71:0];
        checks++;
        if (!obs_q[12][73] || w !== 72'h00_01_02_05_06_07_0A_0B_0C) begin
            errors++;
            $display("FAIL cont_first got %h want 1/000102050607 0A0B0C", obs_q[12]);
        end
        w = obs_q[19][71:0];
        checks++;
        if (obs_q[19][73:72] !== 2'b11 || w !== 72'h07_08_09_0C_0D_0E_11_12_13) begin
            errors++;
            $display("FAIL cont_last got %h want 3/0708090C0D0E111213", obs_q[19]);
        end
        checks++;
        if (count_strobes() != 6 || count_done() != 1) begin
            errors++;
            $display("FAIL cont_counts got strobes=%0d done=%0d want 6 1",
                     count_strobes(), count_done());
        end
    endtask

    task automatic test_extremes();
        logic [71:0] w;
        fill_img(0);
        img[0]  = 8'h80;
        img[6]  = 8'h7F;
        img[12] = 8'hFF;
        send_frame(1'b1, 1'b0, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL extreme px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        w = obs_q[12][71:0];
        checks++;
        if (w !== 72'h80_01_02_05_7F_07_0A_0B_FF) begin
            errors++;
            $display("FAIL extreme_bits got %h want 80010205 7F070A0BFF", w);
        end
        checks++;
        if ($signed(bus.win1) != 0 && obs_q[12][71:64] !== 8'h80) begin
            errors++;
            $display("FAIL extreme_sign got %h want 80", obs_q[12][71:64]);
        end
    endtask

    task automatic test_gaps();
        fill_img(0);
        send_frame(1'b1, 1'b1, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (gap_bad != 0) begin
            errors++;
            $display("FAIL gaps_idle got %0d strobes in gaps want 0", gap_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] w;
        fill_img(0);
        send_frame(1'b1, 1'b0, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_f1 px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        fill_img(100);
        send_frame(1'b0, 1'b0, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_f2 px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        w = obs_q[12][71:0];
        checks++;
        if (w !== 72'h64_65_66_69_6A_6B_6E_6F_70) begin
            errors++;
            $display("FAIL b2b_first got %h want 646566696A6B6E6F70", w);
        end
        checks++;
        if (count_strobes() != 6) begin
            errors++;
            $display("FAIL b2b_count got %0d want 6", count_strobes());
        end
    endtask

    task automatic test_sof_mid();
        fill_img(0);
        send_frame(1'b0, 1'b0, 8);
        model_frame(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sof_old px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        fill_img(50);
        send_frame(1'b1, 1'b0, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sof_new px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (count_strobes() != 6 || count_done() != 1) begin
            errors++;
            $display("FAIL sof_counts got strobes=%0d done=%0d want 6 1",
                     count_strobes(), count_done());
        end
    endtask

    task automatic test_reset_mid();
        logic [73:0] s;
        fill_img(0);
        send_frame(1'b1, 1'b0, 14);
        model_frame(14);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rmid_pre px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        s = snap();
        checks++;
        if (s !== 74'b0) begin
            errors++;
            $display("FAIL rmid_async got %h want 0", s);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_win = '0;
        fill_img(0);
        send_frame(1'b0, 1'b0, NPIX);
        model_frame(NPIX);
        for (int i = 0; i < NPIX; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rmid_post px%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (count_strobes() != 6) begin
            errors++;
            $display("FAIL rmid_count got %0d want 6", count_strobes());
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_extremes();
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
